// File: rtl/display_scan_controller_if.sv
// Handshake and display-pin bundle for display_scan_controller.
// The master side presents values; the slave side (the controller) drives
// the handshake status and the multiplexed seven-segment pins.
interface display_scan_controller_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (
        output in_valid, in_data,
        input  in_ready, busy, done, seg, an
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, busy, done, seg, an
    );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment front end: takes an 8-bit two's-complement value,
// converts it to sign + BCD with a serial shift-add-3 pass, and scans
// sign/hundreds/tens/ones onto a shared active-low segment bus.
module display_scan_controller #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    display_scan_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [17:0] sr_q, sr_d;          // {hun[1:0], ten[3:0], one[3:0], bin[7:0]}
    logic [16:0] sr_adj;              // register after add-3, before the shift
    logic [3:0]  iter_q, iter_d;
    logic        neg_q, neg_d;        // sign of the value being converted
    logic [7:0]  mag;
    logic [1:0]  disp_hun_q, disp_hun_d;
    logic [3:0]  disp_ten_q, disp_ten_d;
    logic [3:0]  disp_one_q, disp_one_d;
    logic        disp_neg_q, disp_neg_d;
    logic        done_q, done_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        accept_s;

    // Active-low pattern for one decimal digit (bit0 = a .. bit6 = g).
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign accept_s     = bus.in_valid && bus.in_ready;

    // Next-state for conversion FSM, display registers and scan multiplexer.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        iter_d     = iter_q;
        neg_d      = neg_q;
        disp_hun_d = disp_hun_q;
        disp_ten_d = disp_ten_q;
        disp_one_d = disp_one_q;
        disp_neg_d = disp_neg_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        seg_d      = seg_q;
        an_d       = an_q;

        // 8-bit negate is enough: 0x80 negates to 0x80, i.e. magnitude 128.
        mag = bus.in_data[7] ? (~bus.in_data + 8'd1) : bus.in_data;

        // Add 3 to any BCD digit >= 5 before shifting; hundreds never exceeds 1.
        sr_adj          = sr_q[16:0];
        sr_adj[11:8]    = (sr_q[11:8]  >= 4'd5) ? (sr_q[11:8]  + 4'd3) : sr_q[11:8];
        sr_adj[15:12]   = (sr_q[15:12] >= 4'd5) ? (sr_q[15:12] + 4'd3) : sr_q[15:12];

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = CONV;
                    neg_d   = bus.in_data[7];
                    sr_d    = {10'd0, mag};
                    iter_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (iter_q == 4'd8) begin
                    // Digits go to the display on the edge entering COMMIT so
                    // the registered seg bus shows them in the done cycle.
                    state_d    = COMMIT;
                    disp_hun_d = sr_q[17:16];
                    disp_ten_d = sr_q[15:12];
                    disp_one_d = sr_q[11:8];
                    disp_neg_d = neg_q;
                    done_d     = 1'b1;
                end else begin
                    sr_d   = {sr_adj, 1'b0};
                    iter_d = iter_q + 4'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Free-running digit scan, independent of conversion.
        if (cnt_q == SCAN_LAST) begin
            cnt_d = 20'd0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        case (idx_d)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = digit_seg(disp_one_d);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = digit_seg(disp_ten_d);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = digit_seg({2'b00, disp_hun_d});
            end
            2'd3: begin
                an_d  = 4'b0111;
                seg_d = disp_neg_d ? 7'b0111111 : 7'b1111111;
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
            end
        endcase
    end

    // State registers with synchronous reset to IDLE and a +000 display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= 18'd0;
            iter_q     <= 4'd0;
            neg_q      <= 1'b0;
            disp_hun_q <= 2'd0;
            disp_ten_q <= 4'd0;
            disp_one_q <= 4'd0;
            disp_neg_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 20'd0;
            idx_q      <= 2'd0;
            seg_q      <= 7'b1000000;
            an_q       <= 4'b1110;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            iter_q     <= iter_d;
            neg_q      <= neg_d;
            disp_hun_q <= disp_hun_d;
            disp_ten_q <= disp_ten_d;
            disp_one_q <= disp_one_d;
            disp_neg_q <= disp_neg_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with SCAN_DIV = 4.
// Stimulus pushes hand-computed digits per accepted value; a monitor pops
// them on done and checks every cycle's seg/an against the current display.
module tb_display_scan_controller;
    logic clk = 1'b0;
    logic rst;

    display_scan_controller_if bus();

    display_scan_controller #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         acc;
        logic [1:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
        logic       neg;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   mcnt  = 0;
    logic [1:0] midx = 2'd0;
    logic seen_rst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b1000000;  4'd1: p = 7'b1111001;
            4'd2: p = 7'b0100100;  4'd3: p = 7'b0110000;
            4'd4: p = 7'b0011001;  4'd5: p = 7'b0010010;
            4'd6: p = 7'b0000010;  4'd7: p = 7'b1111000;
            4'd8: p = 7'b0000000;  4'd9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input exp_t e, input logic [1:0] i);
        logic [6:0] p;
        case (i)
            2'd0: p = pat(e.one);
            2'd1: p = pat(e.ten);
            2'd2: p = pat({2'b00, e.hun});
            default: p = e.neg ? 7'b0111111 : 7'b1111111;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] exp_an(input logic [1:0] i);
        logic [3:0] a;
        case (i)
            2'd0: a = 4'b1110;
            2'd1: a = 4'b1101;
            2'd2: a = 4'b1011;
            default: a = 4'b0111;
        endcase
        return a;
    endfunction

    // Monitor: samples 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            seen_rst = 1'b1;
            exp_q.delete();
            cur  = '{acc: 0, hun: 2'd0, ten: 4'd0, one: 4'd0, neg: 1'b0};
            mcnt = 0;
            midx = 2'd0;
            check("rst_an",       32'(bus.an),       32'(4'b1110));
            check("rst_seg",      32'(bus.seg),      32'(7'b1000000));
            check("rst_busy",     32'(bus.busy),     32'd0);
            check("rst_done",     32'(bus.done),     32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end else if (seen_rst) begin
            if (mcnt == 3) begin
                mcnt = 0;
                midx = midx + 2'd1;
            end else begin
                mcnt++;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("done_latency", 32'(cyc - cur.acc), 32'd10);
                end
            end
            check("an",  32'(bus.an),  32'(exp_an(midx)));
            check("seg", 32'(bus.seg), 32'(exp_seg(cur, midx)));
        end
    end

    // Present a value (called at a negedge); returns negedges waited for in_ready.
    task automatic send(input logic [7:0] v, input logic [1:0] h, input logic [3:0] t,
                        input logic [3:0] o, input logic n, input logic keep, output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        waited = 0;
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back('{acc: cyc, hun: h, ten: t, one: o, neg: n});
            @(negedge clk);
            check("busy_after_accept",  32'(bus.busy),     32'd1);
            check("ready_after_accept", 32'(bus.in_ready), 32'd0);
            bus.in_valid = keep;
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        repeat (20) @(negedge clk);

        send(8'h7F, 2'd1, 4'd2, 4'd7, 1'b0, 1'b0, w); repeat (24) @(negedge clk);
        send(8'h80, 2'd1, 4'd2, 4'd8, 1'b1, 1'b0, w); repeat (24) @(negedge clk);
        send(8'hFF, 2'd0, 4'd0, 4'd1, 1'b1, 1'b0, w); repeat (24) @(negedge clk);
        send(8'h00, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, w); repeat (24) @(negedge clk);

        // Back-to-back: 0x63 held valid during the 0x05 conversion.
        send(8'h05, 2'd0, 4'd0, 4'd5, 1'b0, 1'b1, w);
        bus.in_data = 8'h63;
        send(8'h63, 2'd0, 4'd9, 4'd9, 1'b0, 1'b0, w);
        check("accept_gap", 32'(w), 32'd10);
        repeat (24) @(negedge clk);

        // Abort: reset sampled at E4 of a -100 conversion.
        send(8'h9C, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, w);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(bus.in_ready), 32'd1);
        check("busy_after_abort",  32'(bus.busy),     32'd0);
        repeat (24) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
